// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes and FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational N-bit ALU; unknown op codes return zero data and flag an error.
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] data,
    output logic         err
);

    logic signed [N-1:0] a_s;
    logic signed [N-1:0] b_s;

    assign a_s = signed'(a);
    assign b_s = signed'(b);

    // ADD/SUB wrap modulo 2^N; no carry or overflow is reported.
    always_comb begin
        data = '0;
        err  = 1'b0;
        case (op)
            ALU_AND: data = a & b;
            ALU_OR:  data = a | b;
            ALU_ADD: data = unsigned'(a_s + b_s);
            ALU_SUB: data = unsigned'(a_s - b_s);
            default: err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters,
// one operation in flight, result returned with the issuing requester's id.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [7:0]     req_op,
    input  logic [2*N-1:0] req_a,
    input  logic [2*N-1:0] req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [N-1:0]   rsp_data,
    output logic           rsp_id,
    output logic           rsp_zero,
    output logic           rsp_err
);

    state_t       state;
    state_t       state_next;
    logic         prio;
    logic         grant_id;
    logic         grant;
    logic [3:0]   op_p0;
    logic [N-1:0] a_p0;
    logic [N-1:0] b_p0;
    logic         id_p0;
    logic [N-1:0] alu_data;
    logic         alu_err;

    // Contention goes to prio; a lone requester wins regardless of prio.
    assign grant_id = (&req_valid) ? prio : req_valid[1];

    always_comb begin
        state_next = state;
        req_ready  = 2'b00;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant               = 1'b1;
                    req_ready[grant_id] = 1'b1;
                    state_next          = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            state <= state_next;
            if (grant) begin
                prio <= ~grant_id;
            end
        end
    end

    // Stage p0: operands of the granted requester, held for the EXEC cycle.
    always_ff @(posedge clk) begin
        if (grant) begin
            op_p0 <= grant_id ? req_op[7:4]     : req_op[3:0];
            a_p0  <= grant_id ? req_a[2*N-1:N]  : req_a[N-1:0];
            b_p0  <= grant_id ? req_b[2*N-1:N]  : req_b[N-1:0];
            id_p0 <= grant_id;
        end
    end

    alu_core #(
        .N (N)
    ) u_alu_core (
        .op   (op_p0),
        .a    (a_p0),
        .b    (b_p0),
        .data (alu_data),
        .err  (alu_err)
    );

    // Response registers load only in EXEC, so they hold through RESP and after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_id   <= 1'b0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
        end else if (state == EXEC) begin
            rsp_data <= alu_data;
            rsp_id   <= id_p0;
            rsp_zero <= (alu_data == '0);
            rsp_err  <= alu_err;
        end
    end

    assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed requests, monitor-side checking.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic        id;
        logic        zero;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id;
    logic        rsp_zero;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int grant_cyc = 0;
    int hs_cyc = 0;
    logic lat_pending = 1'b0;
    logic vld_prev = 1'b0;

    logic [31:0] exp_data [2];
    logic        exp_zero [2];
    logic        exp_err  [2];
    rsp_t        sb [$];
    int          gnt_id_q [$];
    int          gnt_cyc_q [$];

    alu_share_arbiter #(.N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: records grants into the scoreboard, checks latency and responses.
    always @(negedge clk) begin
        rsp_t e;
        rsp_t got;
        logic gid;
        if (!rst_n) begin
            sb.delete();
            lat_pending = 1'b0;
            vld_prev    = 1'b0;
        end else begin
            if (req_ready != 2'b00) begin
                check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
                check("ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
                gid    = req_ready[1];
                e.data = exp_data[gid];
                e.id   = gid;
                e.zero = exp_zero[gid];
                e.err  = exp_err[gid];
                sb.push_back(e);
                gnt_id_q.push_back(int'(gid));
                gnt_cyc_q.push_back(cyc);
                grant_cyc   = cyc;
                lat_pending = 1'b1;
            end
            if (rsp_valid && !vld_prev) begin
                check("rsp_without_grant", 64'(lat_pending), 64'd1);
                check("latency", 64'(cyc - grant_cyc), 64'd2);
                lat_pending = 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                hs_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=%0h required=none", rsp_data);
                end else begin
                    got = sb.pop_front();
                    check("rsp_data", 64'(rsp_data), 64'(got.data));
                    check("rsp_id",   64'(rsp_id),   64'(got.id));
                    check("rsp_zero", 64'(rsp_zero), 64'(got.zero));
                    check("rsp_err",  64'(rsp_err),  64'(got.err));
                end
            end
            vld_prev = rsp_valid;
        end
    end

    task automatic drive(input int r, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ed,
                         input logic ez, input logic ee);
        exp_data[r] = ed;
        exp_zero[r] = ez;
        exp_err[r]  = ee;
        req_op[4*r +: 4]  = op;
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
        req_valid[r]      = 1'b1;
    endtask

    // Returns just after the handshake edge of the n-th recorded grant.
    task automatic wait_grants(input int n);
        int t = 0;
        while (gnt_id_q.size() < n && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (gnt_id_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout actual=%0d required=%0d", gnt_id_q.size(), n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while ((sb.size() != 0 || rsp_valid) && t < 100);
        if (sb.size() != 0 || rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_data[i] = '0;
            exp_zero[i] = 1'b0;
            exp_err[i]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_data",  64'(rsp_data),  64'd0);
        check("reset_rsp_id",    64'(rsp_id),    64'd0);
        check("reset_rsp_zero",  64'(rsp_zero),  64'd0);
        check("reset_rsp_err",   64'(rsp_err),   64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request: r0 ADD 5+7.
        drive(0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        @(negedge clk);
        check("single_ready_same_cycle", 64'(req_ready), 64'b01);
        wait_grants(1);
        req_valid = 2'b00;
        drain();

        // Wrap and zero flag from r1; leaves prio at 0.
        gnt_id_q.delete();
        drive(1, ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_grants(1);
        req_valid = 2'b00;
        drain();
        gnt_id_q.delete();
        drive(1, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        wait_grants(1);
        req_valid = 2'b00;
        drain();

        // Round robin with both requesters continuously valid.
        gnt_id_q.delete();
        gnt_cyc_q.delete();
        drive(0, ALU_SUB, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0);
        drive(1, ALU_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0);
        wait_grants(4);
        req_valid = 2'b00;
        check("rr_order0", 64'(gnt_id_q[0]), 64'd0);
        check("rr_order1", 64'(gnt_id_q[1]), 64'd1);
        check("rr_order2", 64'(gnt_id_q[2]), 64'd0);
        check("rr_order3", 64'(gnt_id_q[3]), 64'd1);
        for (int i = 1; i < 4; i++)
            check("rr_interval", 64'(gnt_cyc_q[i] - gnt_cyc_q[i-1]), 64'd3);
        drain();

        // Illegal op from r0: prio must still flip to r1.
        gnt_id_q.delete();
        drive(0, 4'b1111, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1);
        wait_grants(1);
        req_valid = 2'b00;
        drain();

        // Backpressure: both valid, r1 must win, then a 10-cycle stall in RESP.
        gnt_id_q.delete();
        gnt_cyc_q.delete();
        rsp_ready = 1'b0;
        drive(1, ALU_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0);
        drive(0, ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0);
        wait_grants(1);
        check("illegal_prio_flip", 64'(gnt_id_q[0]), 64'd1);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_req_ready", 64'(req_ready), 64'd0);
            check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            check("stall_rsp_data",  64'(rsp_data),  64'h0000_00FF);
            check("stall_rsp_id",    64'(rsp_id),    64'd1);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_grants(2);
        req_valid = 2'b00;
        check("bp_next_grant_id",  64'(gnt_id_q[1]), 64'd0);
        check("bp_next_grant_cyc", 64'(gnt_cyc_q[1] - hs_cyc), 64'd1);
        drain();

        // Reset during EXEC drops the operation; prio returns to 0.
        gnt_id_q.delete();
        drive(0, ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
        wait_grants(1);
        req_valid = 2'b00;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_req_ready", 64'(req_ready), 64'd0);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_rsp_data",  64'(rsp_data),  64'd0);
        check("midrst_rsp_id",    64'(rsp_id),    64'd0);
        check("midrst_rsp_zero",  64'(rsp_zero),  64'd0);
        check("midrst_rsp_err",   64'(rsp_err),   64'd0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        gnt_id_q.delete();
        drive(0, ALU_AND, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0, 1'b0);
        drive(1, ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
        wait_grants(2);
        req_valid = 2'b00;
        check("postrst_first_grant",  64'(gnt_id_q[0]), 64'd0);
        check("postrst_second_grant", 64'(gnt_id_q[1]), 64'd1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
